// File: rtl/msrv32_pkg.sv
// ----------------------------------------------------------------------------
// msrv32_pkg
//   Shared definitions for the msrv32 front end.
//   XLEN          : machine word width (RV32).
//   NOP_INSTR     : RV32I canonical NOP (ADDI x0, x0, 0). It stands in for the
//                   instruction word of entries that never went to memory.
//   fetch_entry_t : one decoded-bound entry {instr, pc, misaligned}.
// ----------------------------------------------------------------------------
package msrv32_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
        logic            misaligned;
    } fetch_entry_t;

endpackage

// File: rtl/msrv32_sync_fifo.sv
// ----------------------------------------------------------------------------
// msrv32_sync_fifo
//   Small single-clock FIFO with a first-word-fall-through head: data_o shows
//   the oldest entry as soon as it has been written.
//   Parameters : WIDTH (entry bits), DEPTH (entries, power of two, >= 2).
//   clk_i      : clock, rising edge.
//   rst_ni     : asynchronous active-low reset (empties the FIFO).
//   clear_i    : synchronous discard of every entry; wins over push/pop.
//   push_i     : write data_i. Accepted when not full, or when full and an
//                entry is popped in the same cycle.
//   pop_i      : remove the head entry (ignored when empty).
//   data_o     : head entry (contents undefined while empty).
//   full_o     : count_o == DEPTH.
//   empty_o    : count_o == 0.
//   count_o    : number of stored entries, $clog2(DEPTH)+1 bits.
// ----------------------------------------------------------------------------
module msrv32_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       clear_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           data_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    // Pointers are AW bits wide, so DEPTH being a power of two makes the
    // natural overflow the modulo-DEPTH wrap.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset: slots are only observed after being written.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
        always_ff @(posedge clk_i) begin
            if (do_push && !clear_i && (wr_ptr_q == AW'(gi))) begin
                mem_q[gi] <= data_i;
            end
        end
    end

endmodule

// File: rtl/msrv32_ifetch_unit.sv
// ----------------------------------------------------------------------------
// msrv32_ifetch_unit
//   Instruction-fetch front end between the stage-1 PC register, the
//   instruction-memory request/response bus and decode.
//   Parameters : DEPTH (max outstanding + buffered fetches), NOP_INSTR.
//   ms_riscv32_mp_clk_in / ms_riscv32_mp_rst_in : clock / async active-low reset.
//   pc_in, pc_valid_in, pc_ready_out   : fetch address handshake with the PC reg.
//   flush_in                           : redirect, drop everything in flight.
//   imem_req_out, imem_addr_out, imem_gnt_in          : request channel.
//   imem_rvalid_in, imem_rdata_in                     : in-order response channel.
//   instr_valid_out, instr_out, instr_pc_out,
//   instr_misaligned_out, instr_ready_in              : entry handshake to decode.
//
//   The PC queue holds the PCs of granted requests awaiting data; the response
//   queue holds finished entries for decode. A fetch needs a credit: the sum of
//   both queues (less an entry retiring this cycle) must be below DEPTH.
//   Misaligned PCs bypass memory and become a NOP entry, but only when nothing
//   is outstanding, so entries stay in program order.
//   After a flush, the drop counter swallows responses for requests that were
//   already on the bus; new fetches may start while it is still counting
//   because the bus answers in order.
// ----------------------------------------------------------------------------
module msrv32_ifetch_unit
    import msrv32_pkg::*;
#(
    parameter int              DEPTH     = 2,
    parameter logic [XLEN-1:0] NOP_INSTR = msrv32_pkg::NOP_INSTR
) (
    input  logic            ms_riscv32_mp_clk_in,
    input  logic            ms_riscv32_mp_rst_in,
    input  logic [XLEN-1:0] pc_in,
    input  logic            pc_valid_in,
    output logic            pc_ready_out,
    input  logic            flush_in,
    output logic            imem_req_out,
    output logic [XLEN-1:0] imem_addr_out,
    input  logic            imem_gnt_in,
    input  logic            imem_rvalid_in,
    input  logic [XLEN-1:0] imem_rdata_in,
    output logic            instr_valid_out,
    output logic [XLEN-1:0] instr_out,
    output logic [XLEN-1:0] instr_pc_out,
    output logic            instr_misaligned_out,
    input  logic            instr_ready_in
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int EW = $bits(fetch_entry_t);

    // run_q is low during reset and for the first edge after it, which keeps
    // every request-side output at 0 while the reset is applied.
    logic            run_q;
    logic [CW-1:0]   drop_q, drop_d;

    logic [XLEN-1:0] pcq_head;
    logic            pcq_push, pcq_pop, pcq_full, pcq_empty;
    logic [CW-1:0]   pcq_count;

    fetch_entry_t    rsp_in, rsp_head;
    logic            rsp_push, rsp_pop, rsp_full, rsp_empty;
    logic [CW-1:0]   rsp_count;

    logic            pc_aligned;
    logic            retire;
    logic [CW-1:0]   occ;
    logic [CW-1:0]   occ_after;
    logic            credit;
    logic            req_accept;
    logic            mis_accept;
    logic            rsp_take;
    logic [CW-1:0]   pending;

    // ------------------------------------------------------------------
    // Request side
    // ------------------------------------------------------------------
    assign pc_aligned = (pc_in[1:0] == 2'b00);
    assign retire     = ~rsp_empty & instr_ready_in;

    // Queues together never exceed DEPTH, so CW bits hold the sum. Counting
    // the retiring entry as free keeps streaming at one per cycle.
    assign occ       = pcq_count + rsp_count;
    assign occ_after = occ - CW'(retire);
    assign credit    = run_q & ~flush_in & (occ_after < CW'(DEPTH));

    assign imem_req_out  = pc_valid_in & credit & pc_aligned;
    assign imem_addr_out = imem_req_out ? pc_in : '0;
    assign req_accept    = imem_req_out & imem_gnt_in;

    assign mis_accept    = pc_valid_in & credit & ~pc_aligned & pcq_empty;
    assign pc_ready_out  = req_accept | mis_accept;

    // ------------------------------------------------------------------
    // Response side
    // ------------------------------------------------------------------
    // A response in a flush cycle, or while the drop counter is nonzero,
    // belongs to a discarded request.
    assign rsp_take = imem_rvalid_in & ~flush_in & (drop_q == '0) & ~pcq_empty;

    assign pcq_push = req_accept;
    assign pcq_pop  = rsp_take;

    // rsp_take needs an outstanding request and mis_accept needs none, so at
    // most one of them pushes in any cycle.
    assign rsp_push = rsp_take | mis_accept;
    assign rsp_pop  = retire;

    always_comb begin
        rsp_in = '0;
        if (mis_accept) begin
            rsp_in.instr      = NOP_INSTR;
            rsp_in.pc         = pc_in;
            rsp_in.misaligned = 1'b1;
        end else begin
            rsp_in.instr      = imem_rdata_in;
            rsp_in.pc         = pcq_head;
            rsp_in.misaligned = 1'b0;
        end
    end

    // On flush everything still on the bus must be swallowed: requests that
    // were already being dropped plus the ones in the PC queue. A response
    // arriving in the flush cycle itself is one of those.
    assign pending = drop_q + pcq_count;

    always_comb begin
        drop_d = drop_q;
        if (flush_in) begin
            drop_d = pending - CW'(imem_rvalid_in && (pending != '0));
        end else if (imem_rvalid_in && (drop_q != '0)) begin
            drop_d = drop_q - CW'(1);
        end
    end

    always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_in) begin
        if (!ms_riscv32_mp_rst_in) begin
            run_q  <= 1'b0;
            drop_q <= '0;
        end else begin
            run_q  <= 1'b1;
            drop_q <= drop_d;
        end
    end

    msrv32_sync_fifo #(
        .WIDTH (XLEN),
        .DEPTH (DEPTH)
    ) u_pc_queue (
        .clk_i   (ms_riscv32_mp_clk_in),
        .rst_ni  (ms_riscv32_mp_rst_in),
        .clear_i (flush_in),
        .push_i  (pcq_push),
        .data_i  (pc_in),
        .pop_i   (pcq_pop),
        .data_o  (pcq_head),
        .full_o  (pcq_full),
        .empty_o (pcq_empty),
        .count_o (pcq_count)
    );

    msrv32_sync_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_rsp_queue (
        .clk_i   (ms_riscv32_mp_clk_in),
        .rst_ni  (ms_riscv32_mp_rst_in),
        .clear_i (flush_in),
        .push_i  (rsp_push),
        .data_i  (rsp_in),
        .pop_i   (rsp_pop),
        .data_o  (rsp_head),
        .full_o  (rsp_full),
        .empty_o (rsp_empty),
        .count_o (rsp_count)
    );

    // ------------------------------------------------------------------
    // Decode side: fields read 0 whenever no entry is presented.
    // ------------------------------------------------------------------
    assign instr_valid_out      = ~rsp_empty;
    assign instr_out            = instr_valid_out ? rsp_head.instr : '0;
    assign instr_pc_out         = instr_valid_out ? rsp_head.pc    : '0;
    assign instr_misaligned_out = instr_valid_out & rsp_head.misaligned;

    // ------------------------------------------------------------------
    // Protocol checks
    // ------------------------------------------------------------------
    // Read data with nothing outstanding and nothing being dropped is a bus
    // protocol error; the logic above ignores it.
    a_rvalid_unexpected : assert property (
        @(posedge ms_riscv32_mp_clk_in) disable iff (!ms_riscv32_mp_rst_in)
        !(imem_rvalid_in && pcq_empty && (drop_q == '0) && !flush_in)
    );

    // Credits must make overflow of either queue impossible.
    a_pcq_overflow : assert property (
        @(posedge ms_riscv32_mp_clk_in) disable iff (!ms_riscv32_mp_rst_in)
        !(pcq_push && pcq_full && !pcq_pop)
    );

    a_rsp_overflow : assert property (
        @(posedge ms_riscv32_mp_clk_in) disable iff (!ms_riscv32_mp_rst_in)
        !(rsp_push && rsp_full && !rsp_pop)
    );

endmodule

// File: tb/tb_msrv32_ifetch_unit.sv
module tb_msrv32_ifetch_unit;

    logic        clk;
    logic        rst_n;
    logic [31:0] pc_in;
    logic        pc_valid_in;
    logic        pc_ready_out;
    logic        flush_in;
    logic        imem_req_out;
    logic [31:0] imem_addr_out;
    logic        imem_gnt_in;
    logic        imem_rvalid_in;
    logic [31:0] imem_rdata_in;
    logic        instr_valid_out;
    logic [31:0] instr_out;
    logic [31:0] instr_pc_out;
    logic        instr_misaligned_out;
    logic        instr_ready_in;

    int n_vec  = 0;
    int n_miss = 0;

    msrv32_ifetch_unit #(
        .DEPTH     (2),
        .NOP_INSTR (32'h0000_0013)
    ) dut (
        .ms_riscv32_mp_clk_in (clk),
        .ms_riscv32_mp_rst_in (rst_n),
        .pc_in                (pc_in),
        .pc_valid_in          (pc_valid_in),
        .pc_ready_out         (pc_ready_out),
        .flush_in             (flush_in),
        .imem_req_out         (imem_req_out),
        .imem_addr_out        (imem_addr_out),
        .imem_gnt_in          (imem_gnt_in),
        .imem_rvalid_in       (imem_rvalid_in),
        .imem_rdata_in        (imem_rdata_in),
        .instr_valid_out      (instr_valid_out),
        .instr_out            (instr_out),
        .instr_pc_out         (instr_pc_out),
        .instr_misaligned_out (instr_misaligned_out),
        .instr_ready_in       (instr_ready_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One cycle of stimulus plus the outputs expected during that cycle.
    typedef struct {
        logic [31:0] pc;
        logic        pv;
        logic        flush;
        logic        gnt;
        logic        rv;
        logic [31:0] rdata;
        logic        rdy;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_prdy;
        logic        e_val;
        logic [31:0] e_instr;
        logic [31:0] e_pc;
        logic        e_mis;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(
        input logic [31:0] pc, input logic [31:0] pv, input logic [31:0] fl,
        input logic [31:0] gnt, input logic [31:0] rv, input logic [31:0] rdata,
        input logic [31:0] rdy, input logic [31:0] e_req, input logic [31:0] e_addr,
        input logic [31:0] e_prdy, input logic [31:0] e_val, input logic [31:0] e_instr,
        input logic [31:0] e_pc, input logic [31:0] e_mis);
        vec_t v;
        v.pc = pc;           v.pv = pv[0];       v.flush = fl[0];
        v.gnt = gnt[0];      v.rv = rv[0];       v.rdata = rdata;
        v.rdy = rdy[0];      v.e_req = e_req[0]; v.e_addr = e_addr;
        v.e_prdy = e_prdy[0]; v.e_val = e_val[0]; v.e_instr = e_instr;
        v.e_pc = e_pc;       v.e_mis = e_mis[0];
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [31:0] pc, input logic pv, input logic fl,
                         input logic gnt, input logic rv, input logic [31:0] rdata,
                         input logic rdy);
        pc_in          = pc;
        pc_valid_in    = pv;
        flush_in       = fl;
        imem_gnt_in    = gnt;
        imem_rvalid_in = rv;
        imem_rdata_in  = rdata;
        instr_ready_in = rdy;
    endtask

    task automatic check_all(input string tag, input logic e_req, input logic [31:0] e_addr,
                             input logic e_prdy, input logic e_val, input logic [31:0] e_instr,
                             input logic [31:0] e_pc, input logic e_mis);
        chk({tag, " imem_req"},   32'(imem_req_out),         32'(e_req));
        chk({tag, " imem_addr"},  imem_addr_out,             e_addr);
        chk({tag, " pc_ready"},   32'(pc_ready_out),         32'(e_prdy));
        chk({tag, " instr_valid"}, 32'(instr_valid_out),     32'(e_val));
        chk({tag, " instr"},      instr_out,                 e_instr);
        chk({tag, " instr_pc"},   instr_pc_out,              e_pc);
        chk({tag, " misaligned"}, 32'(instr_misaligned_out), 32'(e_mis));
    endtask

    initial begin
        rst_n = 1'b0;
        drive(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);

        // ---- streaming: 0x0..0xC, response one cycle after each grant ----
        tbl.push_back(mk(32'h0,   1,0,1,0,0,            1, 1,32'h0,  1, 0,0,0,0));
        tbl.push_back(mk(32'h4,   1,0,1,1,32'hA000_0000,1, 1,32'h4,  1, 0,0,0,0));
        tbl.push_back(mk(32'h8,   1,0,1,1,32'hA000_0004,1, 1,32'h8,  1, 1,32'hA000_0000,32'h0,0));
        tbl.push_back(mk(32'hC,   1,0,1,1,32'hA000_0008,1, 1,32'hC,  1, 1,32'hA000_0004,32'h4,0));
        tbl.push_back(mk(32'h0,   0,0,0,1,32'hA000_000C,1, 0,32'h0,  0, 1,32'hA000_0008,32'h8,0));
        tbl.push_back(mk(32'h0,   0,0,0,0,0,            1, 0,32'h0,  0, 1,32'hA000_000C,32'hC,0));
        // ---- backpressure: decode stalled, credits run out after 2 grants ----
        tbl.push_back(mk(32'h10,  1,0,1,0,0,            0, 1,32'h10, 1, 0,0,0,0));
        tbl.push_back(mk(32'h14,  1,0,1,1,32'hB000_0010,0, 1,32'h14, 1, 0,0,0,0));
        tbl.push_back(mk(32'h18,  1,0,1,1,32'hB000_0014,0, 0,32'h0,  0, 1,32'hB000_0010,32'h10,0));
        tbl.push_back(mk(32'h18,  1,0,1,0,0,            0, 0,32'h0,  0, 1,32'hB000_0010,32'h10,0));
        tbl.push_back(mk(32'h18,  1,0,1,0,0,            0, 0,32'h0,  0, 1,32'hB000_0010,32'h10,0));
        tbl.push_back(mk(32'h18,  1,0,1,0,0,            1, 1,32'h18, 1, 1,32'hB000_0010,32'h10,0));
        tbl.push_back(mk(32'h0,   0,0,0,1,32'hB000_0018,1, 0,32'h0,  0, 1,32'hB000_0014,32'h14,0));
        tbl.push_back(mk(32'h0,   0,0,0,0,0,            1, 0,32'h0,  0, 1,32'hB000_0018,32'h18,0));
        // ---- wait states: grant withheld 3 cycles ----
        tbl.push_back(mk(32'h100, 1,0,0,0,0,            1, 1,32'h100,0, 0,0,0,0));
        tbl.push_back(mk(32'h100, 1,0,0,0,0,            1, 1,32'h100,0, 0,0,0,0));
        tbl.push_back(mk(32'h100, 1,0,0,0,0,            1, 1,32'h100,0, 0,0,0,0));
        tbl.push_back(mk(32'h100, 1,0,1,0,0,            1, 1,32'h100,1, 0,0,0,0));
        tbl.push_back(mk(32'h0,   0,0,0,1,32'hC000_0100,1, 0,32'h0,  0, 0,0,0,0));
        tbl.push_back(mk(32'h0,   0,0,0,0,0,            1, 0,32'h0,  0, 1,32'hC000_0100,32'h100,0));
        // ---- flush with 2 outstanding, stale data dropped, refetch at 0x200 ----
        tbl.push_back(mk(32'h40,  1,0,1,0,0,            1, 1,32'h40, 1, 0,0,0,0));
        tbl.push_back(mk(32'h44,  1,0,1,0,0,            1, 1,32'h44, 1, 0,0,0,0));
        tbl.push_back(mk(32'h48,  1,1,1,0,0,            1, 0,32'h0,  0, 0,0,0,0));
        tbl.push_back(mk(32'h0,   0,0,0,1,32'hDEAD_BEEF,1, 0,32'h0,  0, 0,0,0,0));
        tbl.push_back(mk(32'h200, 1,0,1,1,32'hDEAD_BEEF,1, 1,32'h200,1, 0,0,0,0));
        tbl.push_back(mk(32'h0,   0,0,0,1,32'hE000_0200,1, 0,32'h0,  0, 0,0,0,0));
        tbl.push_back(mk(32'h0,   0,0,0,0,0,            1, 0,32'h0,  0, 1,32'hE000_0200,32'h200,0));
        // ---- misaligned with nothing outstanding ----
        tbl.push_back(mk(32'h102, 1,0,1,0,0,            0, 0,32'h0,  1, 0,0,0,0));
        tbl.push_back(mk(32'h0,   0,0,0,0,0,            1, 0,32'h0,  0, 1,32'h0000_0013,32'h102,1));
        tbl.push_back(mk(32'h0,   0,0,0,0,0,            1, 0,32'h0,  0, 0,0,0,0));
        // ---- misaligned held back until the earlier fetch has returned ----
        tbl.push_back(mk(32'h60,  1,0,1,0,0,            1, 1,32'h60, 1, 0,0,0,0));
        tbl.push_back(mk(32'h66,  1,0,1,0,0,            1, 0,32'h0,  0, 0,0,0,0));
        tbl.push_back(mk(32'h66,  1,0,1,1,32'hF000_0060,1, 0,32'h0,  0, 0,0,0,0));
        tbl.push_back(mk(32'h66,  1,0,1,0,0,            1, 0,32'h0,  1, 1,32'hF000_0060,32'h60,0));
        tbl.push_back(mk(32'h0,   0,0,0,0,0,            1, 0,32'h0,  0, 1,32'h0000_0013,32'h66,1));
        tbl.push_back(mk(32'h0,   0,0,0,0,0,            1, 0,32'h0,  0, 0,0,0,0));

        // ---- reset state ----
        #2;
        check_all("reset", 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // ---- table ----
        for (int i = 0; i < tbl.size(); i++) begin
            @(posedge clk);
            #1;
            drive(tbl[i].pc, tbl[i].pv, tbl[i].flush, tbl[i].gnt, tbl[i].rv,
                  tbl[i].rdata, tbl[i].rdy);
            @(negedge clk);
            $display("row %0d: pc=%h pv=%b fl=%b gnt=%b rv=%b rdy=%b -> req=%b addr=%h prdy=%b val=%b instr=%h ipc=%h mis=%b",
                     i, pc_in, pc_valid_in, flush_in, imem_gnt_in, imem_rvalid_in, instr_ready_in,
                     imem_req_out, imem_addr_out, pc_ready_out, instr_valid_out, instr_out,
                     instr_pc_out, instr_misaligned_out);
            check_all($sformatf("row%0d", i), tbl[i].e_req, tbl[i].e_addr, tbl[i].e_prdy,
                      tbl[i].e_val, tbl[i].e_instr, tbl[i].e_pc, tbl[i].e_mis);
        end

        // ---- asynchronous reset mid-stream ----
        @(posedge clk); #1;
        drive(32'h300, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        @(posedge clk); #1;
        drive(32'h304, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_3300, 1'b0);
        @(posedge clk); #1;
        drive(32'h308, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
        @(negedge clk);
        $display("pre-reset: req=%b addr=%h val=%b instr=%h ipc=%h",
                 imem_req_out, imem_addr_out, instr_valid_out, instr_out, instr_pc_out);
        check_all("pre_reset", 1'b1, 32'h308, 1'b1, 1'b1, 32'h0000_3300, 32'h300, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        $display("async reset (no edge): req=%b val=%b", imem_req_out, instr_valid_out);
        check_all("async_reset", 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        drive(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        drive(32'h400, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        $display("post-reset fetch: req=%b addr=%h prdy=%b val=%b", imem_req_out,
                 imem_addr_out, pc_ready_out, instr_valid_out);
        check_all("post_reset_req", 1'b1, 32'h400, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
        @(posedge clk); #1;
        drive(32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_4400, 1'b1);
        @(negedge clk);
        $display("post-reset rvalid: val=%b", instr_valid_out);
        check_all("post_reset_rv", 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        @(posedge clk); #1;
        drive(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        @(negedge clk);
        $display("post-reset entry: val=%b instr=%h ipc=%h", instr_valid_out, instr_out, instr_pc_out);
        check_all("post_reset_out", 1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_4400, 32'h400, 1'b0);
        @(posedge clk); #1;
        drive(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        check_all("post_reset_idle", 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/msrv32_ifetch_unit.md
Name: msrv32_ifetch_unit

Overview:
- Instruction-fetch front end. Consumes the PC held in the stage-1 PC register and drives the instruction-memory request/response bus.
- Tracks in-flight fetches in order and delivers {instruction, PC} to decode over a valid/ready handshake.
- Supports flush on branch/jump redirect, and flags misaligned PCs without issuing a memory access.

Parameters:
- DEPTH, 2, maximum fetches outstanding plus buffered (in-flight PC queue and response queue depth); power of two, ≥2.
- NOP_INSTR, 32'h0000_0013, instruction word returned with misaligned-PC entries.

Ports:
- ms_riscv32_mp_clk_in  in  1  clock, rising edge.
- ms_riscv32_mp_rst_in  in  1  reset; asynchronous, active-low.
- pc_in  in  32  fetch address from PC register.
- pc_valid_in  in  1  pc_in is valid.
- pc_ready_out  out  1  pc_in accepted this cycle; PC register may advance.
- flush_in  in  1  redirect; discard all outstanding and buffered fetches.
- imem_req_out  out  1  memory request.
- imem_addr_out  out  32  request address (word aligned).
- imem_gnt_in  in  1  memory accepts request this cycle.
- imem_rvalid_in  in  1  read data valid.
- imem_rdata_in  in  32  read data.
- instr_valid_out  out  1  decode entry valid.
- instr_out  out  32  instruction word.
- instr_pc_out  out  32  PC of instr_out.
- instr_misaligned_out  out  1  entry PC had pc[1:0] != 0.
- instr_ready_in  in  1  decode accepts entry.

Behaviour:
- Reset (ms_riscv32_mp_rst_in low, asynchronous): both queues empty, drop counter 0. All outputs 0, so instr_valid_out=0 and imem_req_out=0.
- Credits: occupancy = outstanding (granted, no rvalid yet) + response-queue entries. A new fetch is allowed only when occupancy < DEPTH and flush_in = 0.
- Aligned PC:
  - imem_req_out = pc_valid_in & credit & pc_in[1:0]==0; imem_addr_out = pc_in.
  - Request accepted when imem_req_out & imem_gnt_in; pc_ready_out is asserted the same cycle (combinational from gnt).
  - On accept, pc_in is pushed to the in-flight PC queue.
- Misaligned PC (pc_in[1:0] != 0):
  - No memory request is issued.
  - Accepted (pc_ready_out=1) only when outstanding==0 and credit is available, which preserves ordering.
  - Pushes a response entry {NOP_INSTR, pc_in, misaligned=1}.
- Response path:
  - imem_rvalid_in with drop counter 0: pop the PC queue and push {imem_rdata_in, popped PC, 0} to the response queue.
  - rvalid with nonzero outstanding is guaranteed by the bus. rvalid with outstanding==0 is a protocol error; it is ignored and an assertion must fire.
- Output: head of the response queue drives instr_*. An entry is retired on instr_valid_out & instr_ready_in.
  - Latency: gnt in cycle N, rvalid in cycle ≥N+1, instr_valid_out in cycle after rvalid.
  - Back-to-back streaming: one instruction per cycle when memory answers every cycle and decode is always ready.
- Stall: instr_ready_in=0 holds instr_* stable. Credits block new requests once occupancy==DEPTH.
- Simultaneous events: push and pop in the same cycle is legal at full or empty; occupancy is unchanged.
- Flush (flush_in=1, sampled at clock edge):
  - Response queue is cleared; instr_valid_out=0 next cycle.
  - Drop counter loads the current outstanding count, including a grant in the same cycle (there is none, because requests are suppressed while flush_in=1).
  - PC queue is cleared.
  - Each later rvalid decrements the drop counter and is discarded.
  - New fetches resume the cycle after flush deasserts, even while dropping.
  - rvalid in the flush cycle itself counts toward the drop.
- Reset mid-operation clears all state immediately. The memory side must also be reset; no drop tracking survives reset.
- Width rules: occupancy and drop counters are $clog2(DEPTH)+1 bits; queue pointers wrap modulo DEPTH.

Decomposition:
- Shared package msrv32_pkg holds NOP_INSTR (RV32I ADDI x0,x0,0), the XLEN=32 constant, and the fetch-entry struct {instr, pc, misaligned}.
- One natural sub-module: msrv32_sync_fifo (parameterised width/depth, push/pop/clear, full/empty/count). Instantiate it twice: one for the PC queue, one for the response queue.

Test Plan:
- Streaming: PC 0x0,0x4,0x8,0xC; gnt=1 always, rvalid one cycle after each gnt, ready=1 → four entries on consecutive cycles with matching PCs; first valid 2 cycles after first gnt.
- Backpressure: DEPTH=2, instr_ready_in=0 → exactly 2 grants accepted. imem_req_out=0 thereafter with instr_out held stable. Raising ready resumes fetches.
- Wait states: gnt withheld 3 cycles with pc_in=0x100 → imem_addr_out stable at 0x100 and pc_ready_out=0 until gnt.
- Flush with 2 outstanding: flush_in pulse, then two rvalids with 0xDEAD_BEEF → both dropped. Next fetch at 0x200 returns normally; no stale entry appears.
- Misaligned: pc_in=0x102 with outstanding==0 → no imem_req_out. Entry instr=0x0000_0013, pc=0x102, misaligned=1.
- Async reset: assert ms_riscv32_mp_rst_in low mid-stream with queues non-empty → instr_valid_out and imem_req_out go to 0 without a clock edge. After reset release, the first fetch behaves as from an empty state.
